// File: rtl/instr_encoder_loader.sv
// Boot/test program loader: encodes decoded instruction fields into RV32I words and
// writes them into instruction memory from word 0 until a HALT is written.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   LOAD    | accepting field beats, one memory write per accepted beat
//   DRAIN   | HALT write on the bus, no further beats accepted
//   DONE    | load complete, done held until start or reset
module instr_encoder_loader #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [20:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              overflow
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   localparam logic [2:0]  K_R    = 3'd0;
   localparam logic [2:0]  K_I    = 3'd1;
   localparam logic [2:0]  K_LW   = 3'd2;
   localparam logic [2:0]  K_SW   = 3'd3;
   localparam logic [2:0]  K_BR   = 3'd4;
   localparam logic [2:0]  K_JAL  = 3'd5;
   localparam logic [2:0]  K_JALR = 3'd6;
   localparam logic [31:0] HALT_WORD = 32'h0000_007F;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic [31:0]         enc_word;
   logic                accept;
   logic                is_halt;
   logic                is_full;

   assign in_ready = (state_q == S_LOAD);
   assign accept   = in_valid && in_ready;
   assign is_halt  = (in_kind == 3'd7);
   assign is_full  = (ptr_q == {ADDR_W{1'b1}});

   always_comb begin
      enc_word = HALT_WORD;
      unique case (in_kind)
         K_R:    enc_word = {(in_f7b5 ? 7'h20 : 7'h00), in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
         K_I: begin
            // shift-immediates carry the arithmetic/logical select in bit 30
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
               enc_word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'h13};
            else
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
         end
         K_LW:   enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'h03};
         K_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'h23};
         K_BR:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], 7'h63};
         K_JAL:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
         K_JALR: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
         default: enc_word = HALT_WORD;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               ptr_d   = '0;
               count_d = '0;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               ptr_d   = ptr_q + 1'b1;
               count_d = count_q + 1'b1;
               if (is_halt) begin
                  wdata_d = HALT_WORD;
                  state_d = S_DRAIN;
               end else if (is_full) begin
                  // last slot is reserved for the HALT so the core never runs off the end
                  wdata_d = HALT_WORD;
                  ovf_d   = 1'b1;
                  state_d = S_DRAIN;
               end else begin
                  wdata_d = enc_word;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;
   assign done       = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus pushes expected writes from an
// arithmetic RV32I encoding model; a negedge monitor pops and compares every write.
module tb_instr_encoder_loader;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_ready;
   logic [2:0]    in_kind, in_funct3;
   logic          in_f7b5;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [20:0]   in_imm;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   word_count;
   logic          done, overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];

   int m_ptr, m_count;
   bit m_ovf, m_loading;

   instr_encoder_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_count(word_count),
      .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic int unsigned fld(input int v, input int lo, input int n);
      return (v >>> lo) & ((1 << n) - 1);
   endfunction

   // Reference encoder: each format assembled from field values by shift-and-add.
   function automatic logic [31:0] ref_enc(input int kind, input int f3, input int f7,
                                           input int rd, input int rs1, input int rs2,
                                           input int imm);
      int unsigned w;
      case (kind)
         0: w = ((f7 != 0) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                + f3 * (1 << 12) + rd * (1 << 7) + 'h33;
         1: begin
            if (f3 == 1 || f3 == 5)
               w = f7 * (1 << 30) + fld(imm, 0, 5) * (1 << 20);
            else
               w = fld(imm, 0, 12) * (1 << 20);
            w = w + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 'h13;
         end
         2: w = fld(imm, 0, 12) * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12) + rd * (1 << 7) + 'h03;
         3: w = fld(imm, 5, 7) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12)
                + fld(imm, 0, 5) * (1 << 7) + 'h23;
         4: w = fld(imm, 12, 1) * (1 << 31) + fld(imm, 5, 6) * (1 << 25) + rs2 * (1 << 20)
                + rs1 * (1 << 15) + f3 * (1 << 12) + fld(imm, 1, 4) * (1 << 8)
                + fld(imm, 11, 1) * (1 << 7) + 'h63;
         5: w = fld(imm, 20, 1) * (1 << 31) + fld(imm, 1, 10) * (1 << 21) + fld(imm, 11, 1) * (1 << 20)
                + fld(imm, 12, 8) * (1 << 12) + rd * (1 << 7) + 'h6F;
         6: w = fld(imm, 0, 12) * (1 << 20) + rs1 * (1 << 15) + rd * (1 << 7) + 'h67;
         default: w = 'h7F;
      endcase
      return w;
   endfunction

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (q_data.size() == 0) begin
            chk("unexpected_write", {31'b0, imem_we}, 32'h0);
         end else begin
            chk("write_addr", 32'(imem_addr), q_addr.pop_front());
            chk("write_data", imem_wdata, q_data.pop_front());
         end
      end
   end

   task automatic drive_junk();
      in_kind   = 3'($urandom);
      in_funct3 = 3'($urandom);
      in_f7b5   = 1'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = 21'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic beat(input int kind, input int f3, input int f7, input int rd, input int rs1,
                       input int rs2, input int imm, input bit use_lit, input logic [31:0] lit);
      logic [31:0] exp;
      bit          ends;
      in_kind   = kind[2:0];
      in_funct3 = f3[2:0];
      in_f7b5   = f7[0];
      in_rd     = rd[4:0];
      in_rs1    = rs1[4:0];
      in_rs2    = rs2[4:0];
      in_imm    = imm[20:0];
      in_valid  = 1'b1;
      chk("in_ready_load", {31'b0, in_ready}, 32'h1);
      ends = 1'b0;
      if (kind == 7) begin
         exp  = 32'h7F;
         ends = 1'b1;
      end else if (m_ptr == DEPTH - 1) begin
         exp   = 32'h7F;
         m_ovf = 1'b1;
         ends  = 1'b1;
      end else begin
         exp = use_lit ? lit : ref_enc(kind, f3, f7, rd, rs1, rs2, imm);
      end
      q_addr.push_back(32'(m_ptr));
      q_data.push_back(exp);
      m_ptr++;
      m_count++;
      if (ends) m_loading = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      m_ptr     = 0;
      m_count   = 0;
      m_ovf     = 1'b0;
      m_loading = 1'b1;
   endtask

   // Called at the DRAIN-cycle negedge right after the terminating beat.
   task automatic finish_check();
      chk("in_ready_drain", {31'b0, in_ready}, 32'h0);
      chk("done_in_drain", {31'b0, done}, 32'h0);
      @(negedge clk);
      chk("done", {31'b0, done}, 32'h1);
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("word_count", 32'(word_count), 32'(m_count));
      drive_junk();
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("word_count_hold", 32'(word_count), 32'(m_count));
      chk("sb_empty", 32'(q_data.size()), 32'h0);
   endtask

   task automatic rand_program();
      int imm_s;
      int kind;
      logic [20:0] r;
      do_start();
      while (m_loading) begin
         if ($urandom_range(0, 3) == 0) begin
            drive_junk();
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         r     = 21'($urandom);
         imm_s = {{11{r[20]}}, r};
         kind  = ($urandom_range(0, 11) == 0) ? 7 : int'($urandom_range(0, 6));
         start = ($urandom_range(0, 7) == 0);
         beat(kind, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), imm_s, 1'b0, 32'h0);
      end
      finish_check();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      drive_junk();
      m_loading = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", {31'b0, imem_we}, 32'h0);
      chk("rst_ready", {31'b0, in_ready}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_ovf", {31'b0, overflow}, 32'h0);
      chk("rst_count", 32'(word_count), 32'h0);
      reset = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("idle_ignores_valid", 32'(word_count), 32'h0);

      // directed program with literal expected words, back-to-back
      do_start();
      beat(1, 0, 0, 1, 0, 0, 5, 1'b1, 32'h0050_0093);
      beat(3, 0, 0, 0, 1, 2, 8, 1'b1, 32'h0020_A423);
      beat(0, 0, 1, 3, 1, 2, 0, 1'b1, 32'h4020_81B3);
      beat(4, 0, 0, 0, 1, 2, -4, 1'b1, 32'hFE20_8EE3);
      beat(5, 0, 0, 1, 0, 0, 8, 1'b1, 32'h0080_00EF);
      beat(7, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0000_007F);
      finish_check();

      // memory fills before HALT: last slot forced to HALT
      do_start();
      for (int i = 0; i < DEPTH; i++)
         beat(1, 0, 0, i + 1, 0, 0, i, 1'b0, 32'h0);
      finish_check();

      // HALT landing exactly in the last slot is a normal finish
      do_start();
      for (int i = 0; i < DEPTH - 1; i++)
         beat(6, 0, 0, 2, i, 0, -i, 1'b0, 32'h0);
      beat(7, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
      finish_check();

      // reset mid-stream drops the in-flight beat
      do_start();
      beat(0, 7, 0, 4, 5, 6, 0, 1'b0, 32'h0);
      beat(2, 3, 0, 7, 8, 0, 100, 1'b0, 32'h0);
      reset = 1'b1;
      drive_junk();
      in_kind  = 3'd0;
      in_valid = 1'b1;
      @(negedge clk);
      chk("midrst_we", {31'b0, imem_we}, 32'h0);
      chk("midrst_count", 32'(word_count), 32'h0);
      chk("midrst_addr", 32'(imem_addr), 32'h0);
      chk("midrst_wdata", imem_wdata, 32'h0);
      chk("midrst_ready", {31'b0, in_ready}, 32'h0);
      reset     = 1'b0;
      in_valid  = 1'b0;
      m_loading = 1'b0;
      do_start();
      beat(1, 0, 0, 1, 0, 0, 5, 1'b1, 32'h0050_0093);
      beat(7, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
      finish_check();

      for (int p = 0; p < 40; p++)
         rand_program();

      for (int i = 0; i < 5 && q_data.size() != 0; i++)
         @(negedge clk);
      chk("final_sb_empty", 32'(q_data.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
